reg_file_32x32: RTL and testbench
=================================

# reg_file_32x32

Integer register file for the RV32I single-cycle core, directly upstream of the 32-bit ALU. Two asynchronous read ports supply the ALU A and B operands. One synchronous write port takes the ALU result or load data on writeback. Register x0 is hardwired to zero; all other registers clear on reset.

## Interface
Parameters:
- XLEN, 32, data width (matches ALU operand width)
- NREGS, 32, number of architectural registers
- AW, 5, address width (log2 NREGS)

Ports:
- clk  in  1  core clock; writes on rising edge
- rst  in  1  reset; asynchronous, active-high; clears every register to 0
- rs1_addr  in  AW  read port 1 address (instr[19:15])
- rs2_addr  in  AW  read port 2 address (instr[24:20])
- rs1_data  out  XLEN  read port 1 data, drives ALU A
- rs2_data  out  XLEN  read port 2 data, drives ALU B
- we  in  1  write enable (RegWrite from control)
- rd_addr  in  AW  write address (instr[11:7])
- rd_data  in  XLEN  write data (ALU Y or memory load data)

## Operation
- Storage is registers x1..x31, each XLEN bits. x0 has no storage.
- Read: rsN_data = 0 when rsN_addr == 0, else regs[rsN_addr]. Both ports are purely combinational and fully independent. rs1_addr == rs2_addr is legal, and both ports return the same value.
- Write: on posedge clk with we=1 and rd_addr != 0, regs[rd_addr] <= rd_data.
  - we=1 with rd_addr == 0 is silently discarded.
  - we=0 leaves all registers unchanged.
- Reset: rst=1 forces regs[1..31] to 0 immediately, without waiting for a clock edge. While rst=1, writes are ignored and rs1_data = rs2_data = 0 for any address.
- Reset mid-operation: a write whose clock edge coincides with rst assertion is lost. rst has priority.
- No X propagation: all storage is defined from reset onward.

## Timing
- Read latency: 0 cycles, combinational from address to data.
- Write latency: 1 edge. Data written at edge N is visible on the read ports after edge N.
- Same-cycle read of a register being written: behaviour depends on RF_BYPASS_EN (see Configuration).
- Reset values: rs1_data = 0 and rs2_data = 0 during and immediately after reset.
- Release of rst is asynchronous. The first write honoured is on the first posedge clk with rst=0.

## Configuration
- Macro: RF_BYPASS_EN.
- Defined: write-through forwarding on each read port.
  - If we=1, rd_addr != 0 and rd_addr == rsN_addr, then rsN_data = rd_data in the same cycle, before the edge.
  - Bypass is suppressed while rst=1 and for rd_addr == 0.
- Undefined: read ports return the stored (old) value until the write edge completes.
- Either way, the architectural state after the edge is identical.

## Structure
- Shared package rv_pkg holds:
  - constants XLEN=32, NREGS=32, AW=5
  - localparam REG_ZERO = 5'd0
  - typedef word_t (logic [XLEN-1:0]) and typedef reg_addr_t (logic [AW-1:0])
- One sub-module: rf_read_port, instantiated twice. It implements the address mux, the x0-zero rule and the optional bypass compare.
- The write path and storage stay in the top module.

## Test plan
- Reset clear: write 32'hDEADBEEF to x5, then pulse rst between clock edges. Required: rs1_data = 0 at x5 immediately, before any clock edge.
- x0 hardwired: we=1, rd_addr=0, rd_data=32'hFFFFFFFF, one edge. Required: rs1_addr=0 and rs2_addr=0 both read 0.
- Dual read: write x1=32'd1 and x2=32'd5, then rs1_addr=1, rs2_addr=2. Required: rs1_data=1 and rs2_data=5; forward both to the ALU and confirm Op=10 gives Y=6.
- Write disable: x7=32'h12345678, then we=0 with rd_addr=7, rd_data=0 for one edge. Required: x7 still reads 32'h12345678.
- Same-cycle read/write on x3 (old value 32'hA, new value 32'hB, rs1_addr=3). Required before the edge: 32'hB with RF_BYPASS_EN, 32'hA without. Required after the edge: 32'hB in both builds.
- Reset vs write race: assert rst coincident with a posedge carrying we=1, rd_addr=9, rd_data=32'h55. Required: x9 reads 0 after reset release.

Source files
------------

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV32I constants and types for the integer register file
package rv_pkg;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  localparam logic [AW-1:0] REG_ZERO = 5'd0;

  typedef logic [XLEN-1:0] word_t;
  typedef logic [AW-1:0]   reg_addr_t;

  // Storage for x1..x31 only; x0 has no flops.
  typedef logic [NREGS-1:1][XLEN-1:0] regs_t;
endpackage

// File: rtl/reg_file_32x32_if.sv
// rtl/reg_file_32x32_if.sv - register file access bus (two read ports, one write port)
interface reg_file_32x32_if;
  import rv_pkg::*;

  reg_addr_t rs1_addr;
  reg_addr_t rs2_addr;
  word_t     rs1_data;
  word_t     rs2_data;
  logic      we;
  reg_addr_t rd_addr;
  word_t     rd_data;

  modport master (
    output rs1_addr, rs2_addr, we, rd_addr, rd_data,
    input  rs1_data, rs2_data
  );

  modport slave (
    input  rs1_addr, rs2_addr, we, rd_addr, rd_data,
    output rs1_data, rs2_data
  );
endinterface

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - combinational read port with x0-zero rule
// Optional write-through forwarding when RF_BYPASS_EN is defined.
module rf_read_port
  import rv_pkg::*;
(
  input  logic      i_rst,
  input  regs_t     i_regs,
  input  reg_addr_t i_addr,
  input  logic      i_we,
  input  reg_addr_t i_wr_addr,
  input  word_t     i_wr_data,
  output word_t     o_data
);

`ifdef RF_BYPASS_EN
  logic w_bypass;

  assign w_bypass = !i_rst && i_we && (i_wr_addr != REG_ZERO) && (i_wr_addr == i_addr);

  always_comb begin
    o_data = '0;
    if (w_bypass)
      o_data = i_wr_data;
    else if (i_addr != REG_ZERO)
      o_data = i_regs[i_addr];
  end
`else
  logic w_unused;

  assign w_unused = &{1'b0, i_rst, i_we, i_wr_addr, i_wr_data};

  always_comb begin
    o_data = '0;
    if (i_addr != REG_ZERO)
      o_data = i_regs[i_addr];
  end
`endif

endmodule

// File: rtl/reg_file_32x32.sv
// rtl/reg_file_32x32.sv - RV32I integer register file, 2R1W, x0 hardwired to zero
// Define RF_BYPASS_EN for same-cycle write-through forwarding on both read ports.
module reg_file_32x32
  import rv_pkg::*;
(
  input  logic clk,
  input  logic rst,
  reg_file_32x32_if.slave bus
);

  regs_t r_regs;

  // rst has priority, so a write on an edge that coincides with reset is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_regs <= '0;
    else if (bus.we && (bus.rd_addr != REG_ZERO))
      r_regs[bus.rd_addr] <= bus.rd_data;
  end

  rf_read_port u_rd1 (
    .i_rst     (rst),
    .i_regs    (r_regs),
    .i_addr    (bus.rs1_addr),
    .i_we      (bus.we),
    .i_wr_addr (bus.rd_addr),
    .i_wr_data (bus.rd_data),
    .o_data    (bus.rs1_data)
  );

  rf_read_port u_rd2 (
    .i_rst     (rst),
    .i_regs    (r_regs),
    .i_addr    (bus.rs2_addr),
    .i_we      (bus.we),
    .i_wr_addr (bus.rd_addr),
    .i_wr_data (bus.rd_data),
    .o_data    (bus.rs2_data)
  );

endmodule

// File: tb/tb_reg_file_32x32.sv
// tb/tb_reg_file_32x32.sv - directed self-checking bench for reg_file_32x32 (honours RF_BYPASS_EN)
module tb_reg_file_32x32;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  reg_file_32x32_if bus ();

  reg_file_32x32 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    bus.we      = 1'b1;
    bus.rd_addr = a;
    bus.rd_data = d;
    tick();
    bus.we      = 1'b0;
  endtask

  logic [31:0] alu_y;
  logic [31:0] same_cycle_exp;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst          = 1'b1;
    bus.we       = 1'b0;
    bus.rd_addr  = 5'd0;
    bus.rd_data  = 32'd0;
    bus.rs1_addr = 5'd5;
    bus.rs2_addr = 5'd31;
    #2;
    check("reset_rs1", bus.rs1_data, 32'd0);
    check("reset_rs2", bus.rs2_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset_rs1", bus.rs1_data, 32'd0);

    // Reset clear between edges
    write_reg(5'd5, 32'hDEADBEEF);
    bus.rs1_addr = 5'd5;
    #1;
    check("x5_written", bus.rs1_data, 32'hDEADBEEF);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("x5_async_clear", bus.rs1_data, 32'd0);
    rst = 1'b0;
    #1;
    check("x5_after_release", bus.rs1_data, 32'd0);

    // x0 hardwired
    write_reg(5'd0, 32'hFFFFFFFF);
    bus.rs1_addr = 5'd0;
    bus.rs2_addr = 5'd0;
    #1;
    check("x0_rs1", bus.rs1_data, 32'd0);
    check("x0_rs2", bus.rs2_data, 32'd0);

    // Dual read feeding ALU add
    write_reg(5'd1, 32'd1);
    write_reg(5'd2, 32'd5);
    bus.rs1_addr = 5'd1;
    bus.rs2_addr = 5'd2;
    #1;
    check("dual_rs1", bus.rs1_data, 32'd1);
    check("dual_rs2", bus.rs2_data, 32'd5);
    alu_y = bus.rs1_data + bus.rs2_data;
    check("alu_add_y", alu_y, 32'd6);
    bus.rs1_addr = 5'd2;
    #1;
    check("same_addr_rs1", bus.rs1_data, 32'd5);
    check("same_addr_rs2", bus.rs2_data, 32'd5);

    // Write disable
    write_reg(5'd7, 32'h12345678);
    bus.we      = 1'b0;
    bus.rd_addr = 5'd7;
    bus.rd_data = 32'd0;
    tick();
    bus.rs1_addr = 5'd7;
    #1;
    check("we0_hold_x7", bus.rs1_data, 32'h12345678);

    // Highest register
    write_reg(5'd31, 32'hCAFEF00D);
    bus.rs2_addr = 5'd31;
    #1;
    check("x31_rs2", bus.rs2_data, 32'hCAFEF00D);

    // Same-cycle read/write on x3
    write_reg(5'd3, 32'h0000000A);
    bus.rs1_addr = 5'd3;
    bus.rs2_addr = 5'd3;
    bus.we       = 1'b1;
    bus.rd_addr  = 5'd3;
    bus.rd_data  = 32'h0000000B;
`ifdef RF_BYPASS_EN
    same_cycle_exp = 32'h0000000B;
`else
    same_cycle_exp = 32'h0000000A;
`endif
    #1;
    check("x3_pre_edge_rs1", bus.rs1_data, same_cycle_exp);
    check("x3_pre_edge_rs2", bus.rs2_data, same_cycle_exp);
    tick();
    bus.we = 1'b0;
    #1;
    check("x3_post_edge", bus.rs1_data, 32'h0000000B);

    // No forwarding toward x0
    bus.rs1_addr = 5'd0;
    bus.we       = 1'b1;
    bus.rd_addr  = 5'd0;
    bus.rd_data  = 32'h00000077;
    #1;
    check("x0_no_bypass", bus.rs1_data, 32'd0);
    bus.we = 1'b0;
    tick();

    // Reset coincident with a write edge, held across a second write edge
    bus.we      = 1'b1;
    bus.rd_addr = 5'd9;
    bus.rd_data = 32'h00000055;
    bus.rs1_addr = 5'd9;
    @(posedge clk);
    rst = 1'b1;
    #1;
    check("x9_during_rst", bus.rs1_data, 32'd0);
    tick();
    check("x9_rst_held", bus.rs1_data, 32'd0);
    bus.we = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("x9_after_race", bus.rs1_data, 32'd0);
    bus.rs2_addr = 5'd31;
    #1;
    check("x31_cleared", bus.rs2_data, 32'd0);

    // First honoured write after release
    write_reg(5'd9, 32'h00000055);
    #1;
    check("x9_write_after_rst", bus.rs1_data, 32'h00000055);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
